// File: rtl/nms_pkg.sv
// Shared definitions for the NMS window front end: data widths, adj_score lane
// positions and the frame sequencing states.
package nms_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned ENTRY_W   = 2 * DATA_W;
    localparam int unsigned NUM_LANES = 8;

    localparam int unsigned LANE_TL = 7;
    localparam int unsigned LANE_T  = 6;
    localparam int unsigned LANE_TR = 5;
    localparam int unsigned LANE_L  = 4;
    localparam int unsigned LANE_R  = 3;
    localparam int unsigned LANE_BL = 2;
    localparam int unsigned LANE_B  = 1;
    localparam int unsigned LANE_BR = 0;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        FLUSH
    } nmsState;

endpackage

// File: rtl/nms_line_buffer.sv
// One image row of {score, pixel} entries as a circular buffer: the entry read at
// the current slot is the one written DEPTH shifts earlier, then it is replaced.
module nms_line_buffer
    import nms_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               shiftEn,
    input  logic [ENTRY_W-1:0] wrData,
    output logic [ENTRY_W-1:0] rdData
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   ptr;

    assign rdData = mem[ptr];

    always_ff @(posedge clk) begin
        if (shiftEn) begin
            mem[ptr] <= wrData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (shiftEn) begin
            ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/nms_window_buffer.sv
// Streaming 3x3 score window for NMS: two chained line buffers feed a two-column
// register window; centre k is emitted when pixel k+IMG_W+1 is accepted.
module nms_window_buffer
    import nms_pkg::*;
#(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 48
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_score,
    input  logic [DATA_W-1:0]           in_pixel,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           ref_score,
    output logic [NUM_LANES*DATA_W-1:0] adj_score,
    output logic [DATA_W-1:0]           ref_pixel
);

    localparam int unsigned FRAME = IMG_W * IMG_H;
    localparam int unsigned PIX_W = $clog2(FRAME);
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned FL_W  = $clog2(IMG_W + 1);

    nmsState              state;
    nmsState              stateNext;
    logic                 readyReg;
    logic                 accept;
    logic                 step;
    logic                 emit;
    logic [PIX_W-1:0]     pixIdx;
    logic [FL_W-1:0]      flushCnt;
    logic [COL_W-1:0]     outCol;
    logic [ROW_W-1:0]     outRow;
    logic                 isBorder;

    logic [DATA_W-1:0]    newScore;
    logic [DATA_W-1:0]    newPixel;
    logic [ENTRY_W-1:0]   lb1Rd;
    logic [ENTRY_W-1:0]   lb2Rd;
    logic                 unusedTopPixel;

    logic [DATA_W-1:0]    colA [3];
    logic [DATA_W-1:0]    colB [3];
    logic [DATA_W-1:0]    midPix;
    logic [DATA_W-1:0]    nbr [NUM_LANES];
    logic [NUM_LANES*DATA_W-1:0] adjNext;

    assign in_ready = readyReg;
    assign accept   = in_valid & readyReg;

    always_comb begin
        stateNext = state;
        step      = 1'b0;
        emit      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    step      = 1'b1;
                    stateNext = FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    step = 1'b1;
                    if (pixIdx == PIX_W'(IMG_W + 1)) begin
                        emit      = 1'b1;
                        stateNext = STREAM;
                    end
                end
            end
            STREAM: begin
                if (accept) begin
                    step = 1'b1;
                    emit = 1'b1;
                    if (pixIdx == PIX_W'(FRAME - 1)) begin
                        stateNext = FLUSH;
                    end
                end
            end
            FLUSH: begin
                step = 1'b1;
                emit = 1'b1;
                if (flushCnt == FL_W'(IMG_W)) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            readyReg <= 1'b0;
            pixIdx   <= '0;
            flushCnt <= '0;
            outCol   <= '0;
            outRow   <= '0;
        end else begin
            state    <= stateNext;
            readyReg <= (stateNext != FLUSH);
            if (accept) begin
                pixIdx <= (pixIdx == PIX_W'(FRAME - 1)) ? '0 : pixIdx + 1'b1;
            end
            if (state == FLUSH) begin
                flushCnt <= (stateNext == IDLE) ? '0 : flushCnt + 1'b1;
            end
            if (emit) begin
                if (outCol == COL_W'(IMG_W - 1)) begin
                    outCol <= '0;
                    outRow <= (outRow == ROW_W'(IMG_H - 1)) ? '0 : outRow + 1'b1;
                end else begin
                    outCol <= outCol + 1'b1;
                end
            end
        end
    end

    // Flush steps keep the line buffers moving with dummy data so the last row drains.
    assign newScore = (state == FLUSH) ? '0 : in_score;
    assign newPixel = (state == FLUSH) ? '0 : in_pixel;

    nms_line_buffer #(.DEPTH(IMG_W)) rowAbove (
        .clk     (clk),
        .rst_n   (rst_n),
        .shiftEn (step),
        .wrData  ({newScore, newPixel}),
        .rdData  (lb1Rd)
    );

    nms_line_buffer #(.DEPTH(IMG_W)) rowTwoAbove (
        .clk     (clk),
        .rst_n   (rst_n),
        .shiftEn (step),
        .wrData  (lb1Rd),
        .rdData  (lb2Rd)
    );

    assign unusedTopPixel = ^lb2Rd[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (step) begin
            colA    <= colB;
            colB[0] <= lb2Rd[ENTRY_W-1:DATA_W];
            colB[1] <= lb1Rd[ENTRY_W-1:DATA_W];
            colB[2] <= newScore;
            midPix  <= lb1Rd[DATA_W-1:0];
        end
    end

    // The window's third column is the incoming one, so it is taken straight from the sources.
    always_comb begin
        nbr[LANE_TL] = colA[0];
        nbr[LANE_T]  = colB[0];
        nbr[LANE_TR] = lb2Rd[ENTRY_W-1:DATA_W];
        nbr[LANE_L]  = colA[1];
        nbr[LANE_R]  = lb1Rd[ENTRY_W-1:DATA_W];
        nbr[LANE_BL] = colA[2];
        nbr[LANE_B]  = colB[2];
        nbr[LANE_BR] = newScore;
    end

    assign isBorder = (outRow == '0) || (outRow == ROW_W'(IMG_H - 1)) ||
                      (outCol == '0) || (outCol == COL_W'(IMG_W - 1));

    always_comb begin
        adjNext = '0;
        if (!isBorder) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                adjNext[i*DATA_W +: DATA_W] = nbr[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ref_score <= '0;
            adj_score <= '0;
            ref_pixel <= '0;
        end else begin
            out_valid <= emit;
            if (emit) begin
                ref_score <= isBorder ? '0 : colB[1];
                adj_score <= adjNext;
                ref_pixel <= midPix;
            end
        end
    end

endmodule
